// File: rtl/gci_std_kmc_sync_fifo_ext.sv
// Single-clock show-ahead FIFO with protected access, programmable almost-full/empty
// thresholds and peak tracking. Optional sticky error flags: GCI_STD_KMC_SYNC_FIFO_EXT_ERRFLAG_EN.
module gci_std_kmc_sync_fifo_ext #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int D_N   = 2
) (
  input  logic           iCLOCK,
  input  logic           inRESET,
  input  logic           iREMOVE,
  input  logic [D_N:0]   iAF_THRESH,
  input  logic [D_N:0]   iAE_THRESH,
  output logic [D_N:0]   oCOUNT,
  output logic [D_N:0]   oMAX_COUNT,
  input  logic           iWR_EN,
  input  logic [N-1:0]   iWR_DATA,
  output logic           oWR_FULL,
  output logic           oWR_ALMOST_FULL,
  input  logic           iRD_EN,
  output logic [N-1:0]   oRD_DATA,
  output logic           oRD_EMPTY,
  output logic           oRD_ALMOST_EMPTY,
  output logic           oOVERFLOW,
  output logic           oUNDERFLOW
);

  localparam logic [D_N:0] PTR_ONE = {{D_N{1'b0}}, 1'b1};

  logic [D_N:0] wr_ptr;
  logic [D_N:0] rd_ptr;
  logic [D_N:0] count;
  logic [D_N:0] next_count;
  logic [D_N:0] max_count;
  logic         full;
  logic         empty;
  logic         rd_acc;
  logic         wr_acc;
  logic [N-1:0] mem [DEPTH];

  function automatic logic [D_N:0] peak_of(input logic [D_N:0] held, input logic [D_N:0] cand);
    peak_of = (cand > held) ? cand : held;
  endfunction

  // Occupancy is the modulo pointer distance; the wrap bit makes full == count[D_N].
  assign count      = wr_ptr - rd_ptr;
  assign full       = count[D_N];
  assign empty      = (count == '0);
  assign rd_acc     = iRD_EN & ~empty;
  assign wr_acc     = iWR_EN & (~full | rd_acc);
  assign next_count = count + (wr_acc ? PTR_ONE : '0) - (rd_acc ? PTR_ONE : '0);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      max_count <= '0;
    end else if (iREMOVE) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      max_count <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      max_count <= peak_of(max_count, next_count);
    end
  end

  // Storage is deliberately not reset; on full+write+read the write lands in the slot being popped.
  always_ff @(posedge iCLOCK) begin
    if (wr_acc && !iREMOVE) mem[wr_ptr[D_N-1:0]] <= iWR_DATA;
  end

`ifdef GCI_STD_KMC_SYNC_FIFO_EXT_ERRFLAG_EN
  logic overflow;
  logic underflow;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (iREMOVE) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (iWR_EN && !wr_acc) overflow  <= 1'b1;
      if (iRD_EN && empty)   underflow <= 1'b1;
    end
  end

  assign oOVERFLOW  = overflow;
  assign oUNDERFLOW = underflow;
`else
  assign oOVERFLOW  = 1'b0;
  assign oUNDERFLOW = 1'b0;
`endif

  assign oCOUNT           = count;
  assign oMAX_COUNT       = max_count;
  assign oWR_FULL         = full;
  assign oWR_ALMOST_FULL  = (count >= iAF_THRESH);
  assign oRD_EMPTY        = empty;
  assign oRD_ALMOST_EMPTY = (count <= iAE_THRESH);
  assign oRD_DATA         = mem[rd_ptr[D_N-1:0]];

endmodule

// File: tb/tb_gci_std_kmc_sync_fifo_ext.sv
// Bench for gci_std_kmc_sync_fifo_ext: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_gci_std_kmc_sync_fifo_ext;
  localparam int N = 16;
  localparam int DEPTH = 4;
  localparam int D_N = 2;
`ifdef GCI_STD_KMC_SYNC_FIFO_EXT_ERRFLAG_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         remove = 1'b0;
  logic [D_N:0] af_th = 3'd3;
  logic [D_N:0] ae_th = 3'd1;
  logic         wr_en = 1'b0;
  logic [N-1:0] wr_data = '0;
  logic         rd_en = 1'b0;
  logic [D_N:0] count;
  logic [D_N:0] max_count;
  logic         full;
  logic         almost_full;
  logic [N-1:0] rd_data;
  logic         empty;
  logic         almost_empty;
  logic         overflow;
  logic         underflow;

  gci_std_kmc_sync_fifo_ext #(.N(N), .DEPTH(DEPTH), .D_N(D_N)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iREMOVE(remove),
    .iAF_THRESH(af_th), .iAE_THRESH(ae_th),
    .oCOUNT(count), .oMAX_COUNT(max_count),
    .iWR_EN(wr_en), .iWR_DATA(wr_data),
    .oWR_FULL(full), .oWR_ALMOST_FULL(almost_full),
    .iRD_EN(rd_en), .oRD_DATA(rd_data),
    .oRD_EMPTY(empty), .oRD_ALMOST_EMPTY(almost_empty),
    .oOVERFLOW(overflow), .oUNDERFLOW(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, peak as an int, flags as bits.
  logic [N-1:0] q[$];
  int           max_m = 0;
  bit           ovf_m = 1'b0;
  bit           udf_m = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int sz;
    bit ra, wa;
    if (!rst_n) begin
      q.delete();
      max_m = 0; ovf_m = 1'b0; udf_m = 1'b0;
    end else if (remove) begin
      q.delete();
      max_m = 0; ovf_m = 1'b0; udf_m = 1'b0;
    end else begin
      sz = q.size();
      ra = rd_en && (sz > 0);
      wa = wr_en && ((sz < DEPTH) || ra);
      if (wr_en && !wa) ovf_m = 1'b1;
      if (rd_en && sz == 0) udf_m = 1'b1;
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(wr_data);
      if (q.size() > max_m) max_m = q.size();
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("m_count", count, q.size());
      chk("m_max", max_count, max_m);
      chk("m_full", full, q.size() == DEPTH);
      chk("m_empty", empty, q.size() == 0);
      chk("m_af", almost_full, q.size() >= int'(af_th));
      chk("m_ae", almost_empty, q.size() <= int'(ae_th));
      chk("m_ovf", overflow, ERR & ovf_m);
      chk("m_udf", underflow, ERR & udf_m);
      if (q.size() > 0) chk("m_rd_data", rd_data, q[0]);
    end
  end

  task automatic cyc(input bit w, input logic [N-1:0] d, input bit r, input bit rm);
    wr_en = w; wr_data = d; rd_en = r; remove = rm;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; remove = 1'b0;
  endtask

  logic [N-1:0] seq_a [4];
  logic [N-1:0] seq_b [4];

  initial begin
    int pw, pr;
    seq_a = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    seq_b = '{16'h2222, 16'h3333, 16'h4444, 16'h5555};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_max", max_count, 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, seq_a[i], 1'b0, 1'b0);
      if (i == 2) chk("af_after_3", almost_full, 1);
      if (i == 2) chk("full_after_3", full, 0);
    end
    chk("fill_count", count, 4);
    chk("fill_full", full, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", rd_data, seq_a[i]);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain_empty", empty, 1);
    chk("drain_max", max_count, 4);

    for (int i = 0; i < 4; i++) cyc(1'b1, seq_a[i], 1'b0, 1'b0);
    chk("full_head", rd_data, 16'h1111);
    cyc(1'b1, 16'h5555, 1'b1, 1'b0);
    chk("full_wr_rd_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("after_swap_data", rd_data, seq_b[i]);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("swap_empty", empty, 1);

    cyc(1'b1, 16'hAAAA, 1'b1, 1'b0);
    chk("empty_wr_rd_count", count, 1);
    chk("empty_wr_rd_data", rd_data, 16'hAAAA);
    chk("underflow_flag", underflow, ERR);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("remove_count", count, 0);
    chk("remove_udf", underflow, 0);

    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    chk("over_count", count, 4);
    chk("overflow_flag", overflow, ERR);
    chk("over_head", rd_data, 16'h0100);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("remove2_count", count, 0);
    chk("remove2_max", max_count, 0);
    chk("remove2_ovf", overflow, 0);

    af_th = 3'd0; ae_th = 3'd4;
    #1;
    chk("af_thresh0", almost_full, 1);
    chk("ae_thresh_depth", almost_empty, 1);

    for (int seg = 0; seg < 10; seg++) begin
      af_th = 3'($urandom_range(0, 5));
      ae_th = 3'($urandom_range(0, 5));
      pw = (seg % 3 == 0) ? 80 : (seg % 3 == 1) ? 30 : 55;
      pr = (seg % 3 == 0) ? 30 : (seg % 3 == 1) ? 80 : 50;
      for (int c = 0; c < 80; c++)
        cyc($urandom_range(0, 99) < pw, 16'($urandom), $urandom_range(0, 99) < pr,
            $urandom_range(0, 99) < 2);
      chk("max_bounded", max_count <= 3'(DEPTH), 1);
    end

    af_th = 3'd3; ae_th = 3'd1;
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    cyc(1'b1, 16'h5678, 1'b0, 1'b0);
    wr_en = 1'b1; wr_data = 16'h9ABC;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_max", max_count, 0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_count", count, 0);
    chk("post_rst_ovf", overflow, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
